// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared register-file constants and debug FSM state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } dbg_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_bank_dbg.sv
// ============================================================================
// Module  : reg_bank_dbg
// Brief   : Debug req/ack FSM; captures a register in IDLE, acks in RESP.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_bank_dbg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_req,
  input  logic [DATA_W-1:0] sel_data,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
);

  dbg_state_t        state_q;
  dbg_state_t        state_d;
  logic              capture;
  logic [DATA_W-1:0] cap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      // Loading only on the IDLE->RESP edge keeps dbg_data stable between acks.
      if (capture) cap_q <= sel_data;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    dbg_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (dbg_req) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        dbg_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_data = cap_q;

endmodule

`default_nettype wire

// File: rtl/reg_bank.sv
// ============================================================================
// Module  : reg_bank
// Brief   : 32x32 register file, 2 comb read ports, 1 sync write, debug port.
//           REGBANK_BYPASS_EN enables same-cycle write-to-read forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_bank
  import cpu_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_00E3,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [31:0]       writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [4:0]        readAddrA,
  input  logic [4:0]        readAddrB,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  input  logic              dbg_req,
  input  logic [4:0]        dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic              addr_err,
  output logic [4:0]        last_waddr,
  output logic [CNT_W-1:0]  write_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [4:0]        wr_idx;
  logic              upper_ok;
  logic              wr_valid;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;

  assign wr_idx   = writeAddr[4:0];
  assign upper_ok = (writeAddr[31:5] == 27'd0);
  assign wr_valid = regWrite && upper_ok && (wr_idx != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
      addr_err    <= 1'b0;
      last_waddr  <= '0;
      write_count <= '0;
    end else begin
      addr_err <= regWrite && !upper_ok;
      if (wr_valid) begin
        regs[wr_idx] <= writeData;
        last_waddr   <= wr_idx;
        if (write_count != '1) write_count <= write_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    read_a = (readAddrA == REG_ZERO) ? '0 : regs[readAddrA];
    read_b = (readAddrB == REG_ZERO) ? '0 : regs[readAddrB];
`ifdef REGBANK_BYPASS_EN
    if (wr_valid && (readAddrA == wr_idx)) read_a = writeData;
    if (wr_valid && (readAddrB == wr_idx)) read_b = writeData;
`endif
  end

  assign readDataA = read_a;
  assign readDataB = read_b;

  // Register 0 is never written, so the stored value already reads as zero.
  reg_bank_dbg #(
    .DATA_W (DATA_W)
  ) u_dbg (
    .clk      (clk),
    .reset    (reset),
    .dbg_req  (dbg_req),
    .sel_data (regs[dbg_addr]),
    .dbg_ack  (dbg_ack),
    .dbg_data (dbg_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_bank.sv
// ============================================================================
// Module  : tb_reg_bank
// Brief   : Directed self-checking bench for reg_bank with expectation queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [31:0] writeAddr;
  logic [31:0] writeData;
  logic [4:0]  readAddrA;
  logic [4:0]  readAddrB;
  logic [31:0] readDataA;
  logic [31:0] readDataB;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic        addr_err;
  logic [4:0]  last_waddr;
  logic [15:0] write_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  reg_bank dut (
    .clk         (clk),
    .reset       (reset),
    .regWrite    (regWrite),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .readAddrA   (readAddrA),
    .readAddrB   (readAddrB),
    .readDataA   (readDataA),
    .readDataB   (readDataB),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_ack     (dbg_ack),
    .dbg_data    (dbg_data),
    .addr_err    (addr_err),
    .last_waddr  (last_waddr),
    .write_count (write_count)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    regWrite  = 1'b0;
    writeAddr = '0;
    writeData = '0;
    readAddrA = '0;
    readAddrB = '0;
    dbg_req   = 1'b0;
    dbg_addr  = '0;
    step();
    step();
    reset = 1'b0;
    #1;

    // Reset contents on both ports.
    for (int i = 0; i < 32; i++) begin
      readAddrA = 5'(i);
      readAddrB = 5'(31 - i);
      #1;
      expect_val((i == 29) ? 32'h0000_00E3 : 32'h0);
      chk($sformatf("reset_rdA[%0d]", i), readDataA);
      expect_val((31 - i == 29) ? 32'h0000_00E3 : 32'h0);
      chk($sformatf("reset_rdB[%0d]", 31 - i), readDataB);
    end
    expect_val(32'h0); chk("reset_write_count", {16'h0, write_count});
    expect_val(32'h0); chk("reset_last_waddr", {27'h0, last_waddr});
    expect_val(32'h0); chk("reset_addr_err", {31'h0, addr_err});
    expect_val(32'h0); chk("reset_dbg_ack", {31'h0, dbg_ack});
    expect_val(32'h0); chk("reset_dbg_data", dbg_data);

    // Plain write to reg 8.
    regWrite = 1'b1; writeAddr = 32'd8; writeData = 32'hDEAD_BEEF;
    step();
    regWrite = 1'b0; readAddrA = 5'd8; readAddrB = 5'd0;
    #1;
    expect_val(32'hDEAD_BEEF); chk("wr8_rdA", readDataA);
    expect_val(32'h0);         chk("wr8_rdB", readDataB);
    expect_val(32'd8);         chk("wr8_last_waddr", {27'h0, last_waddr});
    expect_val(32'd1);         chk("wr8_write_count", {16'h0, write_count});

    // Write to reg 0 is silently dropped.
    regWrite = 1'b1; writeAddr = 32'd0; writeData = 32'hFFFF_FFFF;
    step();
    regWrite = 1'b0; readAddrA = 5'd0;
    #1;
    expect_val(32'h0);  chk("wr0_rdA", readDataA);
    expect_val(32'd1);  chk("wr0_write_count", {16'h0, write_count});
    expect_val(32'd8);  chk("wr0_last_waddr", {27'h0, last_waddr});
    expect_val(32'h0);  chk("wr0_addr_err", {31'h0, addr_err});

    // Upper bits set: rejected, low bits alias reg 8 which must stay intact.
    regWrite = 1'b1; writeAddr = 32'h0000_0028; writeData = 32'h5555_5555;
    step();
    regWrite = 1'b0; readAddrA = 5'd8;
    #1;
    expect_val(32'h1);          chk("bad_addr_err_pulse", {31'h0, addr_err});
    expect_val(32'hDEAD_BEEF);  chk("bad_rdA_reg8", readDataA);
    expect_val(32'd1);          chk("bad_write_count", {16'h0, write_count});
    expect_val(32'd8);          chk("bad_last_waddr", {27'h0, last_waddr});
    step();
    expect_val(32'h0);          chk("bad_addr_err_clear", {31'h0, addr_err});

    // Same-cycle write/read collision on reg 5.
    regWrite = 1'b1; writeAddr = 32'd5; writeData = 32'h0000_1234;
    readAddrA = 5'd5; readAddrB = 5'd0;
    #1;
`ifdef REGBANK_BYPASS_EN
    expect_val(32'h0000_1234);
`else
    expect_val(32'h0);
`endif
    chk("collide_rdA", readDataA);
    expect_val(32'h0); chk("collide_rdB_zero", readDataB);
    step();
    regWrite = 1'b0;
    #1;
    expect_val(32'h0000_1234); chk("after_collide_rdA", readDataA);
    expect_val(32'd2);         chk("after_collide_write_count", {16'h0, write_count});

    // Held debug request: acks on cycles 2, 4, 6.
    dbg_addr = 5'd29; dbg_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      #1;
      expect_val((c % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("dbg_ack_cycle%0d", c), {31'h0, dbg_ack});
      expect_val((c == 1) ? 32'h0 : 32'h0000_00E3);
      chk($sformatf("dbg_data_cycle%0d", c), dbg_data);
      step();
    end
    dbg_req = 1'b0;
    step();

    // Debug capture of a register being written this cycle takes the old value.
    dbg_req = 1'b1; dbg_addr = 5'd8;
    regWrite = 1'b1; writeAddr = 32'd8; writeData = 32'hCAFE_F00D;
    step();
    dbg_req = 1'b0; regWrite = 1'b0; readAddrA = 5'd8;
    #1;
    expect_val(32'h1);          chk("dbgwr_ack", {31'h0, dbg_ack});
    expect_val(32'hDEAD_BEEF);  chk("dbgwr_data_old", dbg_data);
    expect_val(32'hCAFE_F00D);  chk("dbgwr_rdA_new", readDataA);
    step();
    expect_val(32'h0);          chk("dbgwr_ack_drop", {31'h0, dbg_ack});
    expect_val(32'hDEAD_BEEF);  chk("dbgwr_data_hold", dbg_data);

    // Reset asserted while in RESP aborts the transaction.
    dbg_req = 1'b1; dbg_addr = 5'd29;
    step();
    dbg_req = 1'b0;
    expect_val(32'h1); chk("pre_abort_ack", {31'h0, dbg_ack});
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    expect_val(32'h0); chk("abort_ack", {31'h0, dbg_ack});
    expect_val(32'h0); chk("abort_dbg_data", dbg_data);
    step();
    expect_val(32'h0); chk("abort_idle_ack", {31'h0, dbg_ack});
    readAddrA = 5'd29; readAddrB = 5'd8;
    #1;
    expect_val(32'h0000_00E3); chk("rst2_rdA_sp", readDataA);
    expect_val(32'h0);         chk("rst2_rdB_reg8", readDataB);
    expect_val(32'h0);         chk("rst2_write_count", {16'h0, write_count});

    // Saturating write counter.
    regWrite = 1'b1; writeAddr = 32'd3;
    for (int i = 0; i < 65537; i++) begin
      writeData = i;
      step();
      if (i == 65533) begin
        expect_val(32'h0000_FFFE); chk("sat_count_fffe", {16'h0, write_count});
      end
      if (i == 65534) begin
        expect_val(32'h0000_FFFF); chk("sat_count_ffff", {16'h0, write_count});
      end
    end
    regWrite = 1'b0; readAddrA = 5'd3;
    #1;
    expect_val(32'h0000_FFFF); chk("sat_count_final", {16'h0, write_count});
    expect_val(32'd3);         chk("sat_last_waddr", {27'h0, last_waddr});
    expect_val(32'd65536);     chk("sat_rdA_reg3", readDataA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
